// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with direct and auto-scan modes.
// Define ONEHOT_DECODER_ACTIVE_LOW_EN for inverted select lines.
module onehot_scan_decoder #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned NUM_OUT = 16,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   idx,
    output logic               valid,
    output logic               err,
    output logic               wrap
);
    localparam int unsigned        CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(NUM_OUT - 1);
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
    localparam logic [NUM_OUT-1:0] OUT_OFF  = '1;
`else
    localparam logic [NUM_OUT-1:0] OUT_OFF  = '0;
`endif

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   idx_nxt, idx_step;
    logic [NUM_OUT-1:0] out_nxt;
    logic               valid_nxt, err_nxt, wrap_nxt;
    logic               sel_ok, step_wraps;

    // Range check against NUM_OUT, which may equal 2**SEL_W.
    assign sel_ok     = 32'(sel) < NUM_OUT;
    assign step_wraps = (idx == IDX_LAST);
    assign idx_step   = step_wraps ? '0 : idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (en) state_nxt = mode ? SCAN : DIRECT;
    end

    always_comb begin
        idx_nxt   = idx;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
        case (state_nxt)
            IDLE: idx_nxt = '0;
            DIRECT: begin
                if (sel_ok) begin
                    idx_nxt   = sel;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            SCAN: begin
                valid_nxt = 1'b1;
                if (state != SCAN) begin
                    // Scan position is never carried over; entry restarts at 0 or the loaded index.
                    idx_nxt = (load && sel_ok) ? sel : '0;
                    err_nxt = load && !sel_ok;
                end else if (load && sel_ok) begin
                    idx_nxt = sel;
                end else begin
                    err_nxt = load;
                    if (cnt == CNT_LAST) begin
                        idx_nxt  = idx_step;
                        wrap_nxt = step_wraps;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: idx_nxt = '0;
        endcase

        out_nxt = OUT_OFF;
        if (valid_nxt) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (idx_nxt == SEL_W'(i)) out_nxt[i] = ~OUT_OFF[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= OUT_OFF;
            idx   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            out   <= out_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            err   <= err_nxt;
            wrap  <= wrap_nxt;
            cnt   <= cnt_nxt;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        valid |-> $onehot(out ^ OUT_OFF));
    a_off: assert property (@(posedge clk) disable iff (!rst_n)
        !valid |-> (out == OUT_OFF));

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder: two parameterisations driven by shared random stimulus.
module tb_onehot_scan_decoder;
    localparam int unsigned N0 = 16, D0 = 1, N1 = 10, D1 = 3;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0]  sel = '0;
    logic [15:0] out0;
    logic [9:0]  out1;
    logic [3:0]  idx0, idx1;
    logic        valid0, err0, wrap0, valid1, err1, wrap1;

    always #5 clk = ~clk;

    onehot_scan_decoder #(.SEL_W(4), .NUM_OUT(N0), .DWELL(D0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .out(out0), .idx(idx0), .valid(valid0), .err(err0), .wrap(wrap0));

    onehot_scan_decoder #(.SEL_W(4), .NUM_OUT(N1), .DWELL(D1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .out(out1), .idx(idx1), .valid(valid1), .err(err1), .wrap(wrap1));

    typedef struct {
        logic [15:0] o0; logic [3:0] i0; logic v0, e0, w0;
        logic [9:0]  o1; logic [3:0] i1; logic v1, e1, w1;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    int unsigned nout[2] = '{N0, N1};
    int unsigned dwl[2]  = '{D0, D1};
    bit          in_scan[2];
    int unsigned anchor[2], age[2], last_idx[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] exp_out(input int unsigned n, input int unsigned i, input bit v);
        logic [31:0] m, r;
        m = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        r = v ? (32'd1 << i) : 32'd0;
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
        r = ~r & m;
`endif
        return r & m;
    endfunction

    // Scan position is anchor + (edges since anchor)/dwell, modulo the line count.
    task automatic model_step(input int d, output int unsigned oi, output bit ov, output bit oe, output bit ow);
        int unsigned n, dw, s;
        bit ok;
        n = nout[d]; dw = dwl[d]; s = 32'(sel); ok = s < n;
        oi = 0; ov = 0; oe = 0; ow = 0;
        if (!rst_n || !en) begin
            in_scan[d] = 0;
        end else if (!mode) begin
            in_scan[d] = 0;
            if (ok) begin oi = s; ov = 1; end
            else begin oi = last_idx[d]; oe = 1; end
        end else begin
            ov = 1;
            if (!in_scan[d]) begin
                in_scan[d] = 1;
                anchor[d] = (load && ok) ? s : 0;
                age[d] = 0;
                oe = load && !ok;
            end else if (load && ok) begin
                anchor[d] = s;
                age[d] = 0;
            end else begin
                oe = load;
                age[d]++;
                if (age[d] % dw == 0 && (anchor[d] + age[d] / dw) % n == 0) ow = 1;
            end
            oi = (anchor[d] + age[d] / dw) % n;
        end
        last_idx[d] = oi;
    endtask

    task automatic predict();
        exp_t e;
        int unsigned i;
        bit v, er, w;
        model_step(0, i, v, er, w);
        e.o0 = 16'(exp_out(N0, i, v)); e.i0 = 4'(i); e.v0 = v; e.e0 = er; e.w0 = w;
        model_step(1, i, v, er, w);
        e.o1 = 10'(exp_out(N1, i, v)); e.i1 = 4'(i); e.v1 = v; e.e1 = er; e.w1 = w;
        q.push_back(e);
    endtask

    task automatic cycle(input bit r_, input bit e_, input bit m_, input bit l_, input logic [3:0] s_);
        @(negedge clk);
        rst_n = r_; en = e_; mode = m_; load = l_; sel = s_;
        predict();
    endtask

    task automatic chk_reset_now();
        chk("async_out0", 32'(out0), exp_out(N0, 0, 0));
        chk("async_idx0", 32'(idx0), 32'd0);
        chk("async_valid0", 32'(valid0), 32'd0);
        chk("async_out1", 32'(out1), exp_out(N1, 0, 0));
        chk("async_idx1", 32'(idx1), 32'd0);
        chk("async_wrap1", 32'(wrap1), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out0", 32'(out0), 32'(e.o0));
                chk("idx0", 32'(idx0), 32'(e.i0));
                chk("valid0", 32'(valid0), 32'(e.v0));
                chk("err0", 32'(err0), 32'(e.e0));
                chk("wrap0", 32'(wrap0), 32'(e.w0));
                chk("out1", 32'(out1), 32'(e.o1));
                chk("idx1", 32'(idx1), 32'(e.i1));
                chk("valid1", 32'(valid1), 32'(e.v1));
                chk("err1", 32'(err1), 32'(e.e1));
                chk("wrap1", 32'(wrap1), 32'(e.w1));
            end
        end
    end

    initial begin : driver
        #1 rst_n = 1'b0;
        #2 chk_reset_now();
        cycle(0, 1, 0, 0, 4'd5);
        cycle(0, 1, 1, 0, 4'd5);
        for (int s = 0; s < 16; s++) cycle(1, 1, 0, 0, 4'(s));
        cycle(1, 1, 0, 0, 4'd14);
        cycle(1, 1, 0, 0, 4'd12);
        cycle(1, 1, 0, 0, 4'd3);
        for (int c = 0; c < 40; c++) cycle(1, 1, 1, 0, 4'd0);
        cycle(1, 1, 1, 1, 4'd3);
        for (int c = 0; c < 8; c++) cycle(1, 1, 1, 0, 4'd0);
        cycle(1, 1, 1, 1, 4'd12);
        for (int c = 0; c < 6; c++) cycle(1, 1, 1, 0, 4'd0);
        cycle(1, 1, 1, 1, 4'd9);
        for (int c = 0; c < 5; c++) cycle(1, 1, 1, 0, 4'd0);
        for (int c = 0; c < 3; c++) cycle(1, 0, 1, 1, 4'd2);
        cycle(1, 1, 1, 1, 4'd5);
        cycle(1, 1, 1, 0, 4'd0);
        cycle(1, 1, 0, 1, 4'd7);
        cycle(1, 1, 1, 1, 4'd14);
        cycle(1, 1, 1, 0, 4'd0);
        for (int c = 0; c < 600; c++)
            cycle(1, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 4'($urandom));
        for (int c = 0; c < 7; c++) cycle(1, 1, 1, 0, 4'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_now();
        cycle(0, 1, 1, 0, 4'd0);
        for (int c = 0; c < 12; c++) cycle(1, 1, 1, 0, 4'd0);
        for (int c = 0; c < 4 && q.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
